mux16_rr_sched: RTL and testbench
=================================

# mux16_rr_sched

Round-robin scheduler that shares the 16:1 bit mux between 16 requesters. Each requester raises a REQ bit. The block grants one requester at a time, drives the mux select, and holds the grant for up to MAX_HOLD accepted transfers. It then rotates priority, so a single downstream consumer sees one source at a time with a valid/ready handshake.

## Interface
Parameters:
- N, 16, number of requesters; fixed at 16 to match the mux width.
- SELW, 4, select width, log2(N).
- MAX_HOLD, 4, maximum accepted transfers per grant; legal range 1..15.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  reset; one clock; reset is synchronous and active-low.
- REQ  input  16  per-requester request; bit i held high while requester i wants the resource.
- IN  input  16  per-requester data bit; routed to OUT through the mux.
- READY  input  1  downstream accepts the current OUT bit.
- SEL  output  4  registered mux select, equal to the index of the granted requester.
- GNT  output  16  registered one-hot grant, all zero when idle.
- VALID  output  1  registered; high while a grant is active.
- OUT  output  1  IN[SEL], combinational from the registered SEL.

## Operation
- Internal state:
  - state in {IDLE, GRANT}.
  - PTR[3:0], the priority pointer.
  - CNT[3:0], the transfer count for the current grant.
- Transfer definition: xfer = VALID & READY.
- Winner: the first i with REQ[i]=1, searching PTR, PTR+1, …, wrapping 15→0.
- IDLE:
  - If REQ≠0, register SEL=winner, GNT=1<<winner, VALID=1, CNT=0, and go to GRANT.
  - Otherwise stay in IDLE with outputs unchanged (VALID=0, GNT=0).
- GRANT:
  - release = ~REQ[SEL] | (xfer & CNT==MAX_HOLD-1).
  - If there is no release and xfer is high, CNT increments.
  - On release, PTR ← SEL+1 (mod 16), and in the same edge:
    - if REQ≠0, re-arbitrate using the new PTR and re-grant with CNT=0, staying in GRANT;
    - otherwise VALID=0, GNT=0, go to IDLE, and SEL keeps its last value.
- A transfer in a cycle where REQ[SEL] is 0 still counts as a transfer for downstream. The block still releases the grant at that edge.
- If the sole remaining requester exhausts MAX_HOLD, it is re-granted immediately with CNT reset to 0. The search wraps back to it.
- Changes in REQ bits other than SEL never disturb an active grant.
- While READY=0, the grant and CNT are frozen indefinitely unless REQ[SEL] drops.

## Timing
- Reset values: SEL=0, GNT=0, VALID=0, PTR=0, CNT=0, state=IDLE, hence OUT=IN[0].
- Reset mid-grant: at the next edge, all state returns to reset values. A handshake in the reset cycle is ignored.
- Grant latency: REQ sampled high at edge k produces VALID/GNT/SEL valid after edge k, i.e. one cycle.
- Hand-off between requesters has zero bubble: VALID stays high across the release edge when other requests are pending.
- OUT has no register stage; it changes in the same cycle as SEL or IN.
- Maximum grant length is MAX_HOLD accepted transfers. Worst-case wait for a continuously requesting source is 15·MAX_HOLD transfers.

## Structure
- Shared include mux_pkg.vh holds:
  - N, SELW, the default MAX_HOLD;
  - state encodings ST_IDLE=1'b0 and ST_GRANT=1'b1.
- One sub-module instance: the existing mux16x1 with .IN(IN), .SEL(SEL), .OUT(OUT).
- The rotating priority search is an internal combinational function or always block; it is not a separate module.

## Test plan
- Reset: RST_N=0 for 2 cycles with REQ=16'hFFFF and IN=16'h0001.
  - Expect SEL=0, GNT=0, VALID=0, OUT=1.
  - After release, the first grant goes to 0 (PTR=0).
- Single requester: REQ=16'h0008, IN=16'h0008, READY=1.
  - The next cycle shows SEL=3, GNT=16'h0008, VALID=1, OUT=1.
  - After 4 transfers, 3 is re-granted with VALID continuously high.
- Rotation: REQ=16'h8001, READY=1, MAX_HOLD=4.
  - Requester 0 is granted for 4 cycles, then 15 for 4 cycles, then 0 again.
  - VALID never drops.
- Back-pressure: REQ=16'h0004, READY=0 for 10 cycles.
  - SEL=2 is held and CNT stays 0.
  - Then READY=1 for 4 cycles, and the grant is released and re-issued to 2.
- Early withdraw: REQ=16'h0012, grant to 1; drop REQ[1] after 1 transfer.
  - At the next edge, SEL=4, GNT=16'h0010, and PTR becomes 2.
- Reset mid-grant: pull RST_N low while SEL=9 and VALID=1.
  - After the edge, SEL=0, GNT=0, VALID=0.
  - After reset, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/mux16_rr_sched_pkg.sv
// Shared constants, FSM encoding and the rotating-priority search
// for the 16-way round-robin mux scheduler.
package mux16_rr_sched_pkg;

   localparam int MUX_N        = 16;
   localparam int MUX_SELW     = 4;
   localparam int MUX_MAX_HOLD = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // First requester at or after ptr, wrapping; returns ptr when req is all zero.
   function automatic logic [MUX_SELW-1:0] rr_pick(input logic [MUX_N-1:0]    req,
                                                   input logic [MUX_SELW-1:0] ptr);
      logic [MUX_SELW-1:0] idx;
      logic                found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < MUX_N; k++) begin
         idx = ptr + MUX_SELW'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux16_rr_sched_mux16x1.sv
// Plain 16:1 bit mux; OUT follows IN and SEL with no register stage.
module mux16x1
   import mux16_rr_sched_pkg::*;
(
   input  logic [MUX_N-1:0]    IN,
   input  logic [MUX_SELW-1:0] SEL,
   output logic                OUT
);

   assign OUT = IN[SEL];

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin grant of a shared 16:1 mux; each grant lasts until the owner
// drops its request or MAX_HOLD transfers are accepted, then priority rotates.
module mux16_rr_sched
   import mux16_rr_sched_pkg::*;
#(
   parameter int N        = MUX_N,
   parameter int SELW     = MUX_SELW,
   parameter int MAX_HOLD = MUX_MAX_HOLD
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [N-1:0]    REQ,
   input  logic [N-1:0]    IN,
   input  logic            READY,
   output logic [SELW-1:0] SEL,
   output logic [N-1:0]    GNT,
   output logic            VALID,
   output logic            OUT
);

   localparam logic [SELW-1:0] HOLD_LAST = SELW'(MAX_HOLD - 1);

   state_t          state, state_n;
   logic [SELW-1:0] ptr, ptr_n;
   logic [SELW-1:0] cnt, cnt_n;
   logic [SELW-1:0] sel_n;
   logic [N-1:0]    gnt_n;
   logic            valid_n;
   logic            xfer;
   logic            release_g;
   logic [SELW-1:0] next_ptr;
   logic [SELW-1:0] winner;

   assign xfer      = VALID & READY;
   assign release_g = ~REQ[SEL] | (xfer & (cnt == HOLD_LAST));
   // Re-arbitration after a release searches from the slot after the owner.
   assign next_ptr  = (state == ST_GRANT && release_g) ? SEL + 1'b1 : ptr;
   assign winner    = rr_pick(REQ, next_ptr);

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      sel_n   = SEL;
      gnt_n   = GNT;
      valid_n = VALID;
      case (state)
         ST_IDLE: begin
            if (|REQ) begin
               sel_n         = winner;
               gnt_n         = '0;
               gnt_n[winner] = 1'b1;
               valid_n       = 1'b1;
               cnt_n         = '0;
               state_n       = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (release_g) begin
               ptr_n = next_ptr;
               if (|REQ) begin
                  sel_n         = winner;
                  gnt_n         = '0;
                  gnt_n[winner] = 1'b1;
                  cnt_n         = '0;
               end else begin
                  gnt_n   = '0;
                  valid_n = 1'b0;
                  state_n = ST_IDLE;
               end
            end else if (xfer) begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= ST_IDLE;
         ptr   <= '0;
         cnt   <= '0;
         SEL   <= '0;
         GNT   <= '0;
         VALID <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         SEL   <= sel_n;
         GNT   <= gnt_n;
         VALID <= valid_n;
      end
   end

   mux16x1 u_mux (
      .IN  (IN),
      .SEL (SEL),
      .OUT (OUT)
   );

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed test-plan scenarios plus random traffic, checked every cycle
// against a per-requester round-robin reference model.
module tb_mux16_rr_sched;

   localparam int MAX_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] din;
   logic        rdy;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        valid;
   logic        out;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit m_active;
   int m_owner;
   int m_ptr;
   int m_cnt;

   always #5 clk = ~clk;

   mux16_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .REQ   (req),
      .IN    (din),
      .READY (rdy),
      .SEL   (sel),
      .GNT   (gnt),
      .VALID (valid),
      .OUT   (out)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++)
         if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_active = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_active) begin
         if (req != 0) begin
            m_owner = pick(req, m_ptr); m_active = 1; m_cnt = 0;
         end
      end else begin
         if (!req[m_owner] || (rdy && m_cnt == MAX_HOLD - 1)) begin
            m_ptr = (m_owner + 1) % 16;
            if (req != 0) begin
               m_owner = pick(req, m_ptr); m_cnt = 0;
            end else begin
               m_active = 0;
            end
         end else if (rdy) begin
            m_cnt++;
         end
      end
   endtask

   task automatic step(input string tag);
      logic [15:0] eg;
      @(posedge clk);
      model_edge();
      #1;
      eg = m_active ? (16'h1 << m_owner) : 16'h0;
      chk({tag, ".sel"},   {12'h0, sel},   16'(m_owner));
      chk({tag, ".gnt"},   gnt,            eg);
      chk({tag, ".valid"}, {15'h0, valid}, {15'h0, m_active});
      chk({tag, ".out"},   {15'h0, out},   {15'h0, din[m_owner]});
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) step("rst");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; req = 16'hFFFF; din = 16'h0001; rdy = 1'b0;
      m_active = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;

      // reset with all requesting
      do_reset(2);
      chk("reset.sel", {12'h0, sel}, 16'h0);
      chk("reset.gnt", gnt, 16'h0);
      chk("reset.valid", {15'h0, valid}, 16'h0);
      chk("reset.out", {15'h0, out}, 16'h1);
      step("first");
      chk("first.gnt", gnt, 16'h0001);

      // single requester, re-granted after MAX_HOLD with no bubble
      do_reset(1);
      req = 16'h0008; din = 16'h0008; rdy = 1'b1;
      step("single");
      chk("single.sel", {12'h0, sel}, 16'd3);
      chk("single.out", {15'h0, out}, 16'h1);
      for (int i = 0; i < 8; i++) begin
         step("single_hold");
         chk("single.valid_hi", {15'h0, valid}, 16'h1);
      end

      // rotation between 0 and 15
      do_reset(1);
      req = 16'h8001; rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step("rot");
         chk("rot.sel", {12'h0, sel}, (i < 4 || i >= 8) ? 16'd0 : 16'd15);
         chk("rot.valid", {15'h0, valid}, 16'h1);
      end

      // back-pressure freezes the grant
      do_reset(1);
      req = 16'h0004; rdy = 1'b0;
      for (int i = 0; i < 10; i++) step("bp_hold");
      chk("bp.sel", {12'h0, sel}, 16'd2);
      rdy = 1'b1;
      for (int i = 0; i < 4; i++) step("bp_run");
      chk("bp.regrant", gnt, 16'h0004);

      // early withdraw
      do_reset(1);
      req = 16'h0012; rdy = 1'b1;
      step("wd_grant");
      chk("wd.first", {12'h0, sel}, 16'd1);
      step("wd_xfer");
      req = 16'h0010;
      step("wd_drop");
      chk("wd.sel", {12'h0, sel}, 16'd4);
      chk("wd.gnt", gnt, 16'h0010);

      // reset mid-grant on requester 9
      req = 16'h0000;
      step("idle");
      req = 16'h0200;
      step("g9");
      chk("g9.sel", {12'h0, sel}, 16'd9);
      req = 16'h0A40;
      do_reset(1);
      chk("midrst.valid", {15'h0, valid}, 16'h0);
      step("post_rst");
      chk("post_rst.sel", {12'h0, sel}, 16'd6);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) req = 16'($urandom & $urandom & $urandom);
         rdy   = ($urandom_range(0, 3) != 0);
         din   = 16'($urandom);
         rst_n = ($urandom_range(0, 149) != 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
